// File: rtl/inst_exec_sequencer.sv
// rtl/inst_exec_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control FSM
//
// Purpose: owns the PC and sequences one instruction at a time through
// FETCH, DECODE, EXEC, optional MEM and WB. It raises the fetch and memory
// strobes, latches the instruction and its micro-command, and halts on
// EBREAK, an undecodable instruction or a fetch/memory timeout.
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_start                     leave IDLE and fetch at o_pc
//   o_pc                        current instruction address
//   o_ifu_req / i_ifu_rvalid / i_ifu_rdata   fetch handshake
//   o_dec_pattern / i_dec_micro / i_dec_hit  decode LUT interface
//   o_inst, o_micro             latched instruction and micro-command
//   i_jump_target               datapath jump address, used in WB
//   o_lsu_req / i_lsu_done      memory access handshake
//   o_rf_wen, o_retire          WB strobes
//   o_retire_cnt                retired instruction counter
//   o_halted, o_halt_code       halt status (01 ebreak, 10 illegal, 11 timeout)
module inst_exec_sequencer #(
   parameter logic [31:0] RESET_PC    = 32'h8000_0000,
   parameter int          TIMEOUT_CYC = 256
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   output logic [31:0] o_pc,
   output logic        o_ifu_req,
   input  logic        i_ifu_rvalid,
   input  logic [31:0] i_ifu_rdata,
   output logic [14:0] o_dec_pattern,
   input  logic [12:0] i_dec_micro,
   input  logic        i_dec_hit,
   output logic [31:0] o_inst,
   output logic [12:0] o_micro,
   input  logic [31:0] i_jump_target,
   output logic        o_lsu_req,
   input  logic        i_lsu_done,
   output logic        o_rf_wen,
   output logic        o_retire,
   output logic [31:0] o_retire_cnt,
   output logic        o_halted,
   output logic [1:0]  o_halt_code
);

   localparam int             WW         = $clog2(TIMEOUT_CYC);
   localparam logic [WW-1:0]  LAST_WAIT  = WW'(TIMEOUT_CYC - 1);
   localparam logic [14:0]    EBREAK_PAT = 15'b0000000_000_11100;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   state_t        r_state;
   logic [31:0]   r_pc;
   logic [31:0]   r_inst;
   logic [12:0]   r_micro;
   logic [31:0]   r_retire_cnt;
   logic [WW-1:0] r_wait_cnt;
   logic          r_ifu_req;
   logic          r_lsu_req;
   logic          r_rf_wen;
   logic          r_retire;
   logic          r_halted;
   logic [1:0]    r_halt_code;

   logic [14:0]   w_pattern;
   logic          w_mem_op;
   logic          w_timeout;

   assign w_pattern = {r_inst[31:25], r_inst[14:12], r_inst[6:2]};
   assign w_mem_op  = (r_micro[9:8] != 2'b00) || (r_micro[7:6] != 2'b00);
   assign w_timeout = (r_wait_cnt == LAST_WAIT);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_inst       <= '0;
         r_micro      <= '0;
         r_retire_cnt <= '0;
         r_wait_cnt   <= '0;
         r_ifu_req    <= 1'b0;
         r_lsu_req    <= 1'b0;
         r_rf_wen     <= 1'b0;
         r_retire     <= 1'b0;
         r_halted     <= 1'b0;
         r_halt_code  <= 2'b00;
      end else begin
         // Counts cycles spent in the current state; every transition
         // below reloads it with zero.
         r_wait_cnt <= r_wait_cnt + WW'(1);
         r_rf_wen   <= 1'b0;
         r_retire   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state    <= S_FETCH;
                  r_ifu_req  <= 1'b1;
                  r_wait_cnt <= '0;
               end
            end
            S_FETCH: begin
               if (i_ifu_rvalid) begin
                  r_inst     <= i_ifu_rdata;
                  r_state    <= S_DECODE;
                  r_ifu_req  <= 1'b0;
                  r_wait_cnt <= '0;
               end else if (w_timeout) begin
                  r_state     <= S_HALT;
                  r_ifu_req   <= 1'b0;
                  r_halted    <= 1'b1;
                  r_halt_code <= 2'b11;
                  r_wait_cnt  <= '0;
               end
            end
            S_DECODE: begin
               r_wait_cnt <= '0;
               // EBREAK is recognised before the LUT result is consulted.
               if (w_pattern == EBREAK_PAT) begin
                  r_state     <= S_HALT;
                  r_halted    <= 1'b1;
                  r_halt_code <= 2'b01;
               end else if (!i_dec_hit) begin
                  r_state     <= S_HALT;
                  r_halted    <= 1'b1;
                  r_halt_code <= 2'b10;
               end else begin
                  r_micro <= i_dec_micro;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_wait_cnt <= '0;
               if (w_mem_op) begin
                  r_state   <= S_MEM;
                  r_lsu_req <= 1'b1;
               end else begin
                  r_state  <= S_WB;
                  r_rf_wen <= r_micro[12];
                  r_retire <= 1'b1;
               end
            end
            S_MEM: begin
               // A completion arriving on the last allowed cycle still wins.
               if (i_lsu_done) begin
                  r_state    <= S_WB;
                  r_lsu_req  <= 1'b0;
                  r_rf_wen   <= r_micro[12];
                  r_retire   <= 1'b1;
                  r_wait_cnt <= '0;
               end else if (w_timeout) begin
                  r_state     <= S_HALT;
                  r_lsu_req   <= 1'b0;
                  r_halted    <= 1'b1;
                  r_halt_code <= 2'b11;
                  r_wait_cnt  <= '0;
               end
            end
            S_WB: begin
               r_retire_cnt <= r_retire_cnt + 32'd1;
               r_pc         <= r_micro[11] ? (i_jump_target & ~32'd1)
                                           : (r_pc + 32'd4);
               r_state      <= S_FETCH;
               r_ifu_req    <= 1'b1;
               r_wait_cnt   <= '0;
            end
            S_HALT: begin
               r_wait_cnt <= '0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_pc          = r_pc;
   assign o_ifu_req     = r_ifu_req;
   assign o_dec_pattern = w_pattern;
   assign o_inst        = r_inst;
   assign o_micro       = r_micro;
   assign o_lsu_req     = r_lsu_req;
   assign o_rf_wen      = r_rf_wen;
   assign o_retire      = r_retire;
   assign o_retire_cnt  = r_retire_cnt;
   assign o_halted      = r_halted;
   assign o_halt_code   = r_halt_code;

endmodule

// File: tb/tb_inst_exec_sequencer.sv
// tb/tb_inst_exec_sequencer.sv - directed self-checking bench for inst_exec_sequencer
module tb_inst_exec_sequencer;

   localparam logic [31:0] RPC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        ifu_rvalid = 1'b0;
   logic [31:0] ifu_rdata = '0;
   logic        lsu_done = 1'b0;
   logic [31:0] jump_target = 32'h8000_0011;
   logic [12:0] dec_micro;
   logic        dec_hit;
   logic [31:0] pc, inst, retire_cnt;
   logic        ifu_req, lsu_req, rf_wen, retire, halted;
   logic [14:0] dec_pattern;
   logic [12:0] micro;
   logic [1:0]  halt_code;

   int errors = 0;
   int checks = 0;
   int mode = 0;
   int ifu_en = 1;
   int lsu_en = 1;
   int lsu_wait = 2;
   int lsu_cnt = 0;

   inst_exec_sequencer #(.RESET_PC(RPC), .TIMEOUT_CYC(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_pc(pc),
      .o_ifu_req(ifu_req), .i_ifu_rvalid(ifu_rvalid), .i_ifu_rdata(ifu_rdata),
      .o_dec_pattern(dec_pattern), .i_dec_micro(dec_micro), .i_dec_hit(dec_hit),
      .o_inst(inst), .o_micro(micro), .i_jump_target(jump_target),
      .o_lsu_req(lsu_req), .i_lsu_done(lsu_done), .o_rf_wen(rf_wen),
      .o_retire(retire), .o_retire_cnt(retire_cnt), .o_halted(halted),
      .o_halt_code(halt_code)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] imem(input logic [31:0] a);
      if (mode == 1) return 32'hFFFF_FFFF;
      if (mode == 2) return 32'h0020_A023;
      case (a)
         32'h8000_0000: return 32'h0000_10B7;   // LUI x1
         32'h8000_0004: return 32'h0080_00EF;   // JAL
         32'h8000_0010: return 32'h0020_A023;   // SW
         32'h8000_0014: return 32'h0010_8093;   // ADDI
         default:       return 32'h0010_0073;   // EBREAK
      endcase
   endfunction

   // Decode LUT keyed on opcode[6:2]; SYSTEM hits so EBREAK priority is visible.
   always_comb begin
      dec_hit   = 1'b1;
      dec_micro = '0;
      case (dec_pattern[4:0])
         5'b01101: dec_micro = 13'b1_0_0_00_00_000_011;
         5'b11011: dec_micro = 13'b1_1_0_00_00_000_100;
         5'b01000: dec_micro = 13'b0_0_0_10_00_000_010;
         5'b00100: dec_micro = 13'b1_0_0_00_00_000_001;
         5'b11100: dec_micro = 13'b1_0_0_00_00_000_000;
         default:  dec_hit   = 1'b0;
      endcase
   end

   // Instruction memory answers in the first FETCH cycle.
   always @(negedge clk) begin
      ifu_rvalid = 1'b0;
      if (rst_n && ifu_req && ifu_en != 0) begin
         ifu_rvalid = 1'b1;
         ifu_rdata  = imem(pc);
      end
   end

   // Data memory completes after lsu_wait extra MEM cycles.
   always @(negedge clk) begin
      lsu_done = 1'b0;
      if (!rst_n || !lsu_req || lsu_en == 0) begin
         lsu_cnt = 0;
      end else if (lsu_cnt == lsu_wait) begin
         lsu_done = 1'b1;
         lsu_cnt  = 0;
      end else begin
         lsu_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic run_to_retire(output int cyc, output int lsu_cyc);
      cyc = -1;
      lsu_cyc = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (lsu_req) lsu_cyc++;
         if (retire) begin
            cyc = k;
            break;
         end
      end
      if (cyc < 0) check_eq("retire_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_to_halt(output int cyc, output int ifu_cyc, output int lsu_cyc);
      cyc = -1;
      ifu_cyc = 0;
      lsu_cyc = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (ifu_req) ifu_cyc++;
         if (lsu_req) lsu_cyc++;
         if (halted) begin
            cyc = k;
            break;
         end
      end
      if (cyc < 0) check_eq("halt_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc, lc, ic;
      tick(2);
      check_eq("rst_pc", pc, RPC);
      check_eq("rst_inst", inst, 32'd0);
      check_eq("rst_micro", 32'(micro), 32'd0);
      check_eq("rst_cnt", retire_cnt, 32'd0);
      check_eq("rst_strobes", {27'd0, ifu_req, lsu_req, rf_wen, retire, halted}, 32'd0);
      check_eq("rst_code", 32'(halt_code), 32'd0);
      rst_n = 1'b1;
      tick(3);
      check_eq("idle_hold", 32'(ifu_req), 32'd0);

      // LUI, JAL, SW, ADDI, EBREAK
      start = 1'b1;
      run_to_retire(cyc, lc);
      check_eq("lui_lat", cyc, 32'd4);
      check_eq("lui_wen", 32'(rf_wen), 32'd1);
      check_eq("lui_pc", pc, 32'h8000_0000);
      check_eq("lui_inst", inst, 32'h0000_10B7);
      check_eq("lui_cnt", retire_cnt, 32'd0);
      run_to_retire(cyc, lc);
      check_eq("jal_lat", cyc, 32'd4);
      check_eq("jal_pc", pc, 32'h8000_0004);
      check_eq("jal_wen", 32'(rf_wen), 32'd1);
      check_eq("jal_micro", 32'(micro), 32'(13'b1_1_0_00_00_000_100));
      check_eq("jal_cnt", retire_cnt, 32'd1);
      run_to_retire(cyc, lc);
      check_eq("sw_pc", pc, 32'h8000_0010);
      check_eq("sw_lsu_cyc", lc, 32'd3);
      check_eq("sw_lat", cyc, 32'(4 + 3));
      check_eq("sw_wen", 32'(rf_wen), 32'd0);
      run_to_retire(cyc, lc);
      check_eq("addi_pc", pc, 32'h8000_0014);
      check_eq("addi_cnt", retire_cnt, 32'd3);
      run_to_halt(cyc, ic, lc);
      check_eq("ebreak_lat", cyc, 32'd3);
      check_eq("ebreak_code", 32'(halt_code), 32'd1);
      check_eq("ebreak_cnt", retire_cnt, 32'd4);
      check_eq("ebreak_pc", pc, 32'h8000_0018);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(3);
      check_eq("halt_sticky", {29'd0, halted, halt_code}, 32'd5);
      check_eq("halt_no_req", 32'(ifu_req), 32'd0);

      // illegal instruction
      do_reset();
      mode = 1;
      start = 1'b1;
      run_to_halt(cyc, ic, lc);
      check_eq("ill_code", 32'(halt_code), 32'd2);
      check_eq("ill_pc", pc, RPC);
      check_eq("ill_cnt", retire_cnt, 32'd0);

      // fetch timeout
      do_reset();
      mode = 0;
      ifu_en = 0;
      start = 1'b1;
      run_to_halt(cyc, ic, lc);
      check_eq("fto_code", 32'(halt_code), 32'd3);
      check_eq("fto_ifu_cyc", ic, 32'd8);
      check_eq("fto_req_off", 32'(ifu_req), 32'd0);

      // lsu_done on the last allowed MEM cycle wins, then a MEM timeout
      do_reset();
      ifu_en = 1;
      mode = 2;
      lsu_wait = 7;
      start = 1'b1;
      run_to_retire(cyc, lc);
      check_eq("mlast_lsu_cyc", lc, 32'd8);
      check_eq("mlast_halted", 32'(halted), 32'd0);
      lsu_en = 0;
      run_to_halt(cyc, ic, lc);
      check_eq("mto_code", 32'(halt_code), 32'd3);
      check_eq("mto_lsu_cyc", lc, 32'd8);
      check_eq("mto_pc", pc, 32'h8000_0004);
      check_eq("mto_cnt", retire_cnt, 32'd1);

      // reset asserted while in MEM
      do_reset();
      lsu_en = 1;
      lsu_wait = 2;
      start = 1'b1;
      run_to_retire(cyc, lc);
      check_eq("rm_first_lsu", lc, 32'd3);
      cyc = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (lsu_req) begin
            cyc = k;
            break;
         end
      end
      check_eq("rm_in_mem", 32'(cyc >= 0), 32'd1);
      check_eq("rm_pc_before", pc, 32'h8000_0004);
      #1 rst_n = 1'b0;
      #1;
      check_eq("rm_lsu_req", 32'(lsu_req), 32'd0);
      check_eq("rm_pc", pc, RPC);
      check_eq("rm_cnt", retire_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(3);
      check_eq("rm_idle", {30'd0, ifu_req, lsu_req}, 32'd0);
      check_eq("rm_halted", 32'(halted), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
